// File: rtl/mon_prod_if.sv
// Handshake and word-memory bus between the exponentiation controller
// (master) and the Montgomery-product engine (slave).
interface mon_prod_if #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int ABITS      = 8,
  parameter int DBITS      = 256
);
  logic                  start;
  logic [1:0]            op_code;
  logic [BITLEN-1:0]     n;
  logic [LOG_BITLEN:0]   mp_count;
  logic [ABITS-1:0]      rd_addr;
  logic [DBITS-1:0]      rd_data;
  logic [DBITS-1:0]      wr_data;
  logic [ABITS-1:0]      wr_addr;
  logic                  wr_en;
  logic                  stop;
  logic [BITLEN-1:0]     P;

  modport master (
    output start, op_code, n, mp_count, rd_data,
    input  rd_addr, wr_data, wr_addr, wr_en, stop, P
  );

  modport slave (
    input  start, op_code, n, mp_count, rd_data,
    output rd_addr, wr_data, wr_addr, wr_en, stop, P
  );
endinterface

// File: rtl/mon_prod_engine.sv
// Radix-2 bit-serial Montgomery product engine: fetches A/B from word
// memory, computes A*B*2^(-mp_count) mod n, writes it to the X slot.
//
// state | meaning
// IDLE  | waiting for start
// FA    | rd_addr points at the A operand
// FB    | A captured from rd_data, rd_addr points at X (B operand)
// LD    | B captured (or forced to 1), accumulator and counter cleared
// LOOP  | one add/halve iteration per cycle; exit check when i == mp_count
// FIX   | single conditional subtraction of n
// WR    | result written to X slot and into P
// DONE  | stop held high until the next start is accepted
module mon_prod_engine #(
  parameter int             BITLEN     = 256,
  parameter int             LOG_BITLEN = 8,
  parameter int             ABITS      = 8,
  parameter int             DBITS      = 256,
  parameter logic [ABITS-1:0] X_ADDR   = '0,
  parameter logic [ABITS-1:0] M_ADDR   = ABITS'(1)
) (
  input  logic clk,
  input  logic rst,
  mon_prod_if.slave bus
);

  localparam int TW = BITLEN + 2;
  localparam logic [1:0] OPXM  = 2'd1;
  localparam logic [1:0] OPX1  = 2'd2;
  localparam logic [1:0] OPRSV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FA, S_FB, S_LD, S_LOOP, S_FIX, S_WR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [BITLEN-1:0]   n_q, n_d;
  logic [LOG_BITLEN:0] mc_q, mc_d;
  logic [BITLEN-1:0]   a_q, a_d;
  logic [BITLEN-1:0]   b_q, b_d;
  logic [TW-1:0]       t_q, t_d;
  logic [LOG_BITLEN:0] i_q, i_d;
  logic [ABITS-1:0]    rd_addr_q, rd_addr_d;
  logic [BITLEN-1:0]   p_q, p_d;
  logic                stop_q, stop_d;

  logic                a_bit;
  logic [TW-1:0]       t1, t2;

  // State and datapath registers with synchronous reset; reset aborts any
  // operation in flight and clears P and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      n_q       <= '0;
      mc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      i_q       <= '0;
      rd_addr_q <= '0;
      p_q       <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      n_q       <= n_d;
      mc_q      <= mc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      i_q       <= i_d;
      rd_addr_q <= rd_addr_d;
      p_q       <= p_d;
      stop_q    <= stop_d;
    end
  end

  // Next-state and datapath update. T is two bits wider than n so that
  // T + B + n (< 4n) never overflows before the halving shift.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    n_d       = n_q;
    mc_d      = mc_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    i_d       = i_q;
    rd_addr_d = rd_addr_q;
    p_d       = p_q;
    stop_d    = stop_q;

    a_bit = a_q[i_q[LOG_BITLEN-1:0]];
    t1    = t_q + (a_bit ? {2'b00, b_q} : '0);
    t2    = t1 + (t1[0] ? {2'b00, n_q} : '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          op_d      = bus.op_code;
          n_d       = bus.n;
          mc_d      = bus.mp_count;
          stop_d    = 1'b0;
          rd_addr_d = (bus.op_code == OPXM) ? M_ADDR : X_ADDR;
          state_d   = S_FA;
        end
      end
      S_FA: begin
        rd_addr_d = X_ADDR;
        state_d   = S_FB;
      end
      S_FB: begin
        a_d = bus.rd_data[BITLEN-1:0];
        // Reserved op: nothing is computed or written, just report done.
        if (op_q == OPRSV) begin
          stop_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LD;
        end
      end
      S_LD: begin
        b_d     = (op_q == OPX1) ? BITLEN'(1) : bus.rd_data[BITLEN-1:0];
        t_d     = '0;
        i_d     = '0;
        state_d = S_LOOP;
      end
      S_LOOP: begin
        if (i_q == mc_q) begin
          state_d = S_FIX;
        end else begin
          t_d = t2 >> 1;
          i_d = i_q + 1'b1;
        end
      end
      S_FIX: begin
        if (t_q >= {2'b00, n_q}) t_d = t_q - {2'b00, n_q};
        state_d = S_WR;
      end
      S_WR: begin
        p_d     = t_q[BITLEN-1:0];
        stop_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: write strobe only in WR, read address and flags from flops.
  always_comb begin
    bus.wr_en   = (state_q == S_WR);
    bus.wr_addr = X_ADDR;
    bus.wr_data = (state_q == S_WR) ? DBITS'(t_q[BITLEN-1:0]) : '0;
    bus.rd_addr = rd_addr_q;
    bus.stop    = stop_q;
    bus.P       = p_q;
  end

endmodule

// File: tb/tb_mon_prod_engine.sv
// Bench for mon_prod_engine: synchronous word memory model, scoreboard of
// expected write-back values, one task per scenario.
module tb_mon_prod_engine;
  localparam int BITLEN     = 256;
  localparam int LOG_BITLEN = 8;
  localparam int ABITS      = 8;
  localparam int DBITS      = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mon_prod_if #(.BITLEN(BITLEN), .LOG_BITLEN(LOG_BITLEN), .ABITS(ABITS), .DBITS(DBITS)) bus();

  mon_prod_engine #(.BITLEN(BITLEN), .LOG_BITLEN(LOG_BITLEN), .ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DBITS-1:0] mem [0:255];
  logic             ld_en = 1'b0;
  logic [ABITS-1:0] ld_addr = '0;
  logic [DBITS-1:0] ld_data = '0;

  logic [DBITS-1:0] exp_q [$];
  int wr_cnt = 0;

  // per-operation observations
  int          edges;
  int          stop_edge;
  int          wr_edge;
  int          wr_seen;
  logic        stop_e0;
  logic [ABITS-1:0] ra0, ra1;
  logic        saw_addr1;
  logic [BITLEN+1:0] tr [0:31];

  // Word memory: read data one cycle after address; DUT and bench preload writes.
  always @(posedge clk) begin
    bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en === 1'b1) mem[bus.wr_addr] <= bus.wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Scoreboard: every write-back must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      logic [DBITS-1:0] e;
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got wr_data=%0h, expected no write", bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_data !== e) begin
          n_fail++;
          $display("FAIL wr_data: got %0h expected %0h", bus.wr_data, e);
        end
      end
      n_checks++;
      if (bus.wr_addr !== '0) begin
        n_fail++;
        $display("FAIL wr_addr: got %0h expected 0", bus.wr_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Issue one start and record what happens until stop rises (bounded).
  // edges = number of posedges after the one that sampled start.
  task automatic do_op(input logic [1:0] op, input logic [8:0] mc, input int inject_at);
    bus.op_code  = op;
    bus.mp_count = mc;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    edges     = 0;
    stop_e0   = bus.stop;
    ra0       = bus.rd_addr;
    ra1       = '0;
    saw_addr1 = (bus.rd_addr == ABITS'(1));
    tr[0]     = dut.t_q;
    stop_edge = -1;
    wr_edge   = -1;
    wr_seen   = 0;
    while (stop_edge < 0 && edges < 400) begin
      bus.start = (edges == inject_at);
      @(negedge clk);
      edges++;
      if (edges == 1) ra1 = bus.rd_addr;
      if (bus.rd_addr == ABITS'(1)) saw_addr1 = 1'b1;
      if (edges < 32) tr[edges] = dut.t_q;
      if (bus.wr_en === 1'b1) begin
        wr_seen++;
        wr_edge = edges;
      end
      if (bus.stop === 1'b1) stop_edge = edges;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_code = '0;
    bus.mp_count = '0;
    bus.n = BITLEN'(13);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %0b expected 0", bus.stop); end
    n_checks++; if (bus.P !== '0) begin n_fail++; $display("FAIL reset_P: got %0h expected 0", bus.P); end
    n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", bus.wr_en); end
    n_checks++; if (bus.rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0h expected 0", bus.rd_addr); end
    n_checks++; if (bus.wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0h expected 0", bus.wr_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 5*5*16^-1 mod 13 = 4
  task automatic test_opxx();
    load(0, DBITS'(5));
    exp_q.push_back(DBITS'(4));
    do_op(2'd0, 9'd4, -1);
    n_checks++; if (stop_e0 !== 1'b0) begin n_fail++; $display("FAIL opxx_stop_e0: got %0b expected 0", stop_e0); end
    n_checks++; if (stop_edge != 10) begin n_fail++; $display("FAIL opxx_latency: got %0d expected 10", stop_edge); end
    n_checks++; if (wr_seen != 1 || wr_edge != 9) begin n_fail++; $display("FAIL opxx_wr_en: got count %0d at edge %0d expected 1 at 9", wr_seen, wr_edge); end
    n_checks++; if (bus.P !== BITLEN'(4)) begin n_fail++; $display("FAIL opxx_P: got %0h expected 4", bus.P); end
    n_checks++; if (mem[0] !== DBITS'(4)) begin n_fail++; $display("FAIL opxx_mem0: got %0h expected 4", mem[0]); end
  endtask

  // 7*5*9 mod 13 = 3
  task automatic test_opxm();
    load(0, DBITS'(5));
    load(1, DBITS'(7));
    exp_q.push_back(DBITS'(3));
    do_op(2'd1, 9'd4, -1);
    n_checks++; if (ra0 !== ABITS'(1)) begin n_fail++; $display("FAIL opxm_rd_addr_fa: got %0h expected 1", ra0); end
    n_checks++; if (ra1 !== ABITS'(0)) begin n_fail++; $display("FAIL opxm_rd_addr_fb: got %0h expected 0", ra1); end
    n_checks++; if (stop_edge != 10) begin n_fail++; $display("FAIL opxm_latency: got %0d expected 10", stop_edge); end
    n_checks++; if (bus.P !== BITLEN'(3)) begin n_fail++; $display("FAIL opxm_P: got %0h expected 3", bus.P); end
    n_checks++; if (mem[0] !== DBITS'(3)) begin n_fail++; $display("FAIL opxm_mem0: got %0h expected 3", mem[0]); end
  endtask

  // 5*1*9 mod 13 = 6; accumulator after each iteration 7,10,12,6
  task automatic test_opx1();
    logic [BITLEN+1:0] exp_t [0:3];
    exp_t[0] = 7; exp_t[1] = 10; exp_t[2] = 12; exp_t[3] = 6;
    load(0, DBITS'(5));
    exp_q.push_back(DBITS'(6));
    do_op(2'd2, 9'd4, -1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (tr[4+k] !== exp_t[k]) begin n_fail++; $display("FAIL opx1_t_iter%0d: got %0d expected %0d", k, tr[4+k], exp_t[k]); end
    end
    n_checks++; if (saw_addr1 !== 1'b0) begin n_fail++; $display("FAIL opx1_no_m_read: got addr1 read=%0b expected 0", saw_addr1); end
    n_checks++; if (bus.P !== BITLEN'(6)) begin n_fail++; $display("FAIL opx1_P: got %0h expected 6", bus.P); end
  endtask

  // OPXX (-> 4), then OPXM with X=4, M=7: 7*4*9 mod 13 = 5; a start pulse in LOOP is ignored
  task automatic test_back_to_back();
    load(0, DBITS'(5));
    load(1, DBITS'(7));
    exp_q.push_back(DBITS'(4));
    do_op(2'd0, 9'd4, -1);
    @(negedge clk);
    exp_q.push_back(DBITS'(5));
    do_op(2'd1, 9'd4, 5);
    n_checks++; if (stop_e0 !== 1'b0) begin n_fail++; $display("FAIL b2b_stop_drop: got %0b expected 0", stop_e0); end
    n_checks++; if (stop_edge != 10) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 10", stop_edge); end
    n_checks++; if (wr_seen != 1) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 1", wr_seen); end
    n_checks++; if (bus.P !== BITLEN'(5)) begin n_fail++; $display("FAIL b2b_P: got %0h expected 5", bus.P); end
  endtask

  task automatic test_reset_mid();
    int wr_before;
    load(0, DBITS'(5));
    exp_q.push_back(DBITS'(4));
    wr_before = wr_cnt;
    bus.op_code  = 2'd0;
    bus.mp_count = 9'd4;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_checks++; if (bus.stop !== 1'b0) begin n_fail++; $display("FAIL rstmid_stop: got %0b expected 0", bus.stop); end
    n_checks++; if (bus.P !== '0) begin n_fail++; $display("FAIL rstmid_P: got %0h expected 0", bus.P); end
    n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_en: got %0b expected 0", bus.wr_en); end
    n_checks++; if (dut.state_q !== '0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected IDLE(0)", dut.state_q); end
    repeat (12) @(negedge clk);
    n_checks++; if (wr_cnt != wr_before) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_cnt - wr_before); end
    n_checks++; if (mem[0] !== DBITS'(5)) begin n_fail++; $display("FAIL rstmid_mem0: got %0h expected 5", mem[0]); end
    exp_q.push_back(DBITS'(4));
    do_op(2'd0, 9'd4, -1);
    n_checks++; if (stop_edge != 10) begin n_fail++; $display("FAIL rstmid_rerun_latency: got %0d expected 10", stop_edge); end
    n_checks++; if (bus.P !== BITLEN'(4)) begin n_fail++; $display("FAIL rstmid_rerun_P: got %0h expected 4", bus.P); end
  endtask

  task automatic test_reserved();
    do_op(2'd3, 9'd4, -1);
    n_checks++; if (stop_edge != 2) begin n_fail++; $display("FAIL rsv_latency: got %0d expected 2", stop_edge); end
    n_checks++; if (wr_seen != 0) begin n_fail++; $display("FAIL rsv_wr_en: got %0d writes expected 0", wr_seen); end
    n_checks++; if (bus.P !== BITLEN'(4)) begin n_fail++; $display("FAIL rsv_P: got %0h expected 4", bus.P); end
  endtask

  task automatic test_mc_zero();
    load(0, DBITS'(5));
    exp_q.push_back(DBITS'(0));
    do_op(2'd0, 9'd0, -1);
    n_checks++; if (stop_edge != 6) begin n_fail++; $display("FAIL mc0_latency: got %0d expected 6", stop_edge); end
    n_checks++; if (wr_seen != 1 || wr_edge != 5) begin n_fail++; $display("FAIL mc0_wr_en: got count %0d at edge %0d expected 1 at 5", wr_seen, wr_edge); end
    n_checks++; if (bus.P !== '0) begin n_fail++; $display("FAIL mc0_P: got %0h expected 0", bus.P); end
    n_checks++; if (mem[0] !== '0) begin n_fail++; $display("FAIL mc0_mem0: got %0h expected 0", mem[0]); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op_code  = '0;
    bus.mp_count = '0;
    bus.n        = BITLEN'(13);
    test_reset();
    test_opxx();
    test_opxm();
    test_opx1();
    test_back_to_back();
    test_reset_mid();
    test_reserved();
    test_mc_zero();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
